// File: rtl/axi_lite_delay_slave_regs.sv
// axi_lite_delay_slave_regs
//   AXI4-Lite target with four 32-bit read/write registers and a programmable
//   response latency. It gives master-side latency measurement logic a known,
//   repeatable reference, and emits one-cycle completion pulses per transaction.
//
// Ports
//   ACLK, ARESET        clock (rising edge), asynchronous active-high reset
//   S_AXI_AW*/W*/B*     write address, write data, write response channels
//   S_AXI_AR*/R*        read address, read data channels
//   wr_done, rd_done    one-cycle pulses after the B / R handshake edge
//
// Map: word index = ADDR[3:2], mapped only when ADDR[ADDR_WIDTH-1:4] == 0.
// Unmapped writes are dropped with DECERR; unmapped reads return 0 with DECERR.
// Every output is driven straight from a flop.
module axi_lite_delay_slave_regs #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int RESP_DELAY = 0
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]              S_AXI_AWPROT,
   input  logic                    S_AXI_AWVALID,
   output logic                    S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                    S_AXI_WVALID,
   output logic                    S_AXI_WREADY,
   output logic [1:0]              S_AXI_BRESP,
   output logic                    S_AXI_BVALID,
   input  logic                    S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]              S_AXI_ARPROT,
   input  logic                    S_AXI_ARVALID,
   output logic                    S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]              S_AXI_RRESP,
   output logic                    S_AXI_RVALID,
   input  logic                    S_AXI_RREADY,
   output logic                    wr_done,
   output logic                    rd_done
);

   localparam logic [1:0] W_IDLE  = 2'd0, W_DELAY = 2'd1, W_RESP = 2'd2;
   localparam logic [1:0] R_IDLE  = 2'd0, R_DELAY = 2'd1, R_RESP = 2'd2;
   localparam logic [1:0] OKAY    = 2'b00, DECERR = 2'b11;

   logic [DATA_WIDTH-1:0]   regs_q [4], regs_d [4];

   logic [1:0]              wstate_q, wstate_d;
   logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic [7:0]              wcnt_q, wcnt_d;
   logic                    awready_q, awready_d, wready_q, wready_d;
   logic                    bvalid_q, bvalid_d, wr_done_q, wr_done_d;
   logic [1:0]              bresp_q, bresp_d;

   logic [1:0]              rstate_q, rstate_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [7:0]              rcnt_q, rcnt_d;
   logic                    arready_q, arready_d, rvalid_q, rvalid_d;
   logic                    rd_done_q, rd_done_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;

   logic wmap, rmap;
   assign wmap = ~|awaddr_q[ADDR_WIDTH-1:4];
   assign rmap = ~|araddr_q[ADDR_WIDTH-1:4];

   // PROT and the byte-offset address bits carry no meaning for this target
   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, awaddr_q[1:0], araddr_q[1:0]};

   always_comb begin
      regs_d    = regs_q;
      wstate_d  = wstate_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wcnt_d    = wcnt_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      wr_done_d = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            if (S_AXI_AWVALID && awready_q) begin
               aw_held_d = 1'b1;
               awaddr_d  = S_AXI_AWADDR;
            end
            if (S_AXI_WVALID && wready_q) begin
               w_held_d = 1'b1;
               wdata_d  = S_AXI_WDATA;
               wstrb_d  = S_AXI_WSTRB;
            end
            if (aw_held_d && w_held_d) begin
               wcnt_d   = 8'(RESP_DELAY);
               wstate_d = W_DELAY;
            end
         end
         W_DELAY: begin
            if (wcnt_q != 8'd0) begin
               wcnt_d = wcnt_q - 8'd1;
            end else begin
               if (wmap) begin
                  for (int b = 0; b < DATA_WIDTH/8; b++)
                     if (wstrb_q[b]) regs_d[awaddr_q[3:2]][8*b +: 8] = wdata_q[8*b +: 8];
               end
               bresp_d  = wmap ? OKAY : DECERR;
               bvalid_d = 1'b1;
               wstate_d = W_RESP;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) begin
               bvalid_d  = 1'b0;
               wr_done_d = 1'b1;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               wstate_d  = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
      // READY flops are computed from next state so they are valid the cycle they apply
      awready_d = (wstate_d == W_IDLE) && !aw_held_d;
      wready_d  = (wstate_d == W_IDLE) && !w_held_d;

      rstate_d  = rstate_q;
      araddr_d  = araddr_q;
      rcnt_d    = rcnt_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rd_done_d = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            if (S_AXI_ARVALID && arready_q) begin
               araddr_d = S_AXI_ARADDR;
               rcnt_d   = 8'(RESP_DELAY);
               rstate_d = R_DELAY;
            end
         end
         R_DELAY: begin
            if (rcnt_q != 8'd0) begin
               rcnt_d = rcnt_q - 8'd1;
            end else begin
               // regs_q is the pre-commit value if a write lands on this same edge
               rdata_d  = rmap ? regs_q[araddr_q[3:2]] : '0;
               rresp_d  = rmap ? OKAY : DECERR;
               rvalid_d = 1'b1;
               rstate_d = R_RESP;
            end
         end
         R_RESP: begin
            if (S_AXI_RREADY) begin
               rvalid_d  = 1'b0;
               rd_done_d = 1'b1;
               rstate_d  = R_IDLE;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
      arready_d = (rstate_d == R_IDLE);
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
         wstate_q  <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wcnt_q    <= '0;
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         wr_done_q <= 1'b0;
         rstate_q  <= R_IDLE;
         araddr_q  <= '0;
         rcnt_q    <= '0;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= OKAY;
         rd_done_q <= 1'b0;
      end else begin
         regs_q    <= regs_d;
         wstate_q  <= wstate_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wcnt_q    <= wcnt_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         wr_done_q <= wr_done_d;
         rstate_q  <= rstate_d;
         araddr_q  <= araddr_d;
         rcnt_q    <= rcnt_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rd_done_q <= rd_done_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign wr_done       = wr_done_q;
   assign rd_done       = rd_done_q;

endmodule

// File: tb/tb_axi_lite_delay_slave_regs.sv
// tb_axi_lite_delay_slave_regs
//   Directed bench for axi_lite_delay_slave_regs. Two instances share the data
//   and address buses: u_d0 (RESP_DELAY=0) and u_d4 (RESP_DELAY=4). 'sel'
//   routes the handshake signals to one instance and muxes its outputs back.
//   Inputs are driven and outputs sampled on the falling edge.
module tb_axi_lite_delay_slave_regs;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic [5:0]  awaddr = '0, araddr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;

   logic [1:0]  awready_w, wready_w, bvalid_w, arready_w, rvalid_w, wr_done_w, rd_done_w;
   logic [1:0]  bresp_w [2];
   logic [1:0]  rresp_w [2];
   logic [31:0] rdata_w [2];

   logic        awready, wready, bvalid, arready, rvalid, wr_done, rd_done;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   int n_chk = 0, n_fail = 0, n_wr = 0, n_rd = 0;

   always #5 clk = ~clk;

   axi_lite_delay_slave_regs #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .RESP_DELAY(0)) u_d0 (
      .ACLK(clk), .ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid && !sel),
      .S_AXI_AWREADY(awready_w[0]),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid && !sel),
      .S_AXI_WREADY(wready_w[0]),
      .S_AXI_BRESP(bresp_w[0]), .S_AXI_BVALID(bvalid_w[0]), .S_AXI_BREADY(bready && !sel),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid && !sel),
      .S_AXI_ARREADY(arready_w[0]),
      .S_AXI_RDATA(rdata_w[0]), .S_AXI_RRESP(rresp_w[0]), .S_AXI_RVALID(rvalid_w[0]),
      .S_AXI_RREADY(rready && !sel),
      .wr_done(wr_done_w[0]), .rd_done(rd_done_w[0])
   );

   axi_lite_delay_slave_regs #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .RESP_DELAY(4)) u_d4 (
      .ACLK(clk), .ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid && sel),
      .S_AXI_AWREADY(awready_w[1]),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid && sel),
      .S_AXI_WREADY(wready_w[1]),
      .S_AXI_BRESP(bresp_w[1]), .S_AXI_BVALID(bvalid_w[1]), .S_AXI_BREADY(bready && sel),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid && sel),
      .S_AXI_ARREADY(arready_w[1]),
      .S_AXI_RDATA(rdata_w[1]), .S_AXI_RRESP(rresp_w[1]), .S_AXI_RVALID(rvalid_w[1]),
      .S_AXI_RREADY(rready && sel),
      .wr_done(wr_done_w[1]), .rd_done(rd_done_w[1])
   );

   assign awready = sel ? awready_w[1] : awready_w[0];
   assign wready  = sel ? wready_w[1]  : wready_w[0];
   assign bvalid  = sel ? bvalid_w[1]  : bvalid_w[0];
   assign arready = sel ? arready_w[1] : arready_w[0];
   assign rvalid  = sel ? rvalid_w[1]  : rvalid_w[0];
   assign wr_done = sel ? wr_done_w[1] : wr_done_w[0];
   assign rd_done = sel ? rd_done_w[1] : rd_done_w[0];
   assign bresp   = sel ? bresp_w[1]   : bresp_w[0];
   assign rresp   = sel ? rresp_w[1]   : rresp_w[0];
   assign rdata   = sel ? rdata_w[1]   : rdata_w[0];

   always @(negedge clk) begin
      if (wr_done) n_wr++;
      if (rd_done) n_rd++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Both channels presented together; lat = edges from the last AW/W handshake
   // edge until BVALID is seen.
   task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
      int t;
      logic aw_go, w_go;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      t = 0;
      while ((awvalid || wvalid) && t < 50) begin
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         @(negedge clk);
         if (aw_go) awvalid = 1'b0;
         if (w_go)  wvalid  = 1'b0;
         t++;
      end
      chk("wr_addr_timeout", 32'(t < 50), 32'd1);
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      lat = 0;
      while (!bvalid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("wr_resp_timeout", 32'(lat < 50), 32'd1);
      resp = bresp;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
      int t;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      t = 0;
      while (!arready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("rd_addr_timeout", 32'(t < 50), 32'd1);
      @(negedge clk);
      arvalid = 1'b0; rready = 1'b1;
      lat = 0;
      while (!rvalid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("rd_resp_timeout", 32'(lat < 50), 32'd1);
      d = rdata; resp = rresp;
      @(negedge clk);
      rready = 1'b0;
   endtask

   logic [31:0] exp_regs [4];
   logic [31:0] rd;
   logic [1:0]  rsp, rsp0;
   int          lat, wr0, t;

   initial begin
      exp_regs[0] = 32'h1;
      exp_regs[1] = 32'hFF00FF00;
      exp_regs[2] = 32'hA5A55A5A;
      exp_regs[3] = 32'h4;

      repeat (3) @(negedge clk);
      // reset state, both instances
      for (int k = 0; k < 2; k++) begin
         sel = k[0];
         #1;
         chk("rst_awready", 32'(awready), 32'd1);
         chk("rst_wready",  32'(wready),  32'd1);
         chk("rst_arready", 32'(arready), 32'd1);
         chk("rst_bvalid",  32'(bvalid),  32'd0);
         chk("rst_rvalid",  32'(rvalid),  32'd0);
         chk("rst_rdata",   rdata,        32'd0);
         chk("rst_resp",    32'({bresp, rresp}), 32'd0);
         chk("rst_done",    32'({wr_done, rd_done}), 32'd0);
      end
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // write/readback with zero extra latency
      for (int i = 0; i < 4; i++) begin
         wr0 = n_wr;
         axi_write(6'(4*i), 32'(i+1), 4'hF, rsp, lat);
         chk("wb_bresp", 32'(rsp), 32'd0);
         chk("wb_wlat",  32'(lat), 32'd1);
         @(negedge clk);
         chk("wb_wr_done", 32'(n_wr - wr0), 32'd1);
      end
      for (int i = 0; i < 4; i++) begin
         wr0 = n_rd;
         axi_read(6'(4*i), rd, rsp, lat);
         chk("wb_rdata", rd, 32'(i+1));
         chk("wb_rresp", 32'(rsp), 32'd0);
         chk("wb_rlat",  32'(lat), 32'd1);
         @(negedge clk);
         chk("wb_rd_done", 32'(n_rd - wr0), 32'd1);
      end

      // byte strobes: clear lanes 0 and 2 only
      axi_write(6'h04, 32'hFFFFFFFF, 4'hF, rsp, lat);
      axi_write(6'h04, 32'h00000000, 4'b0101, rsp, lat);
      axi_read(6'h04, rd, rsp, lat);
      chk("strb_rdata", rd, 32'hFF00FF00);
      // low address bits ignored: 0x0E decodes to word 3
      axi_read(6'h0E, rd, rsp, lat);
      chk("lowbits_rdata", rd, 32'h4);

      // W leads AW by 3 cycles; BREADY held low for 5 cycles
      wr0 = n_wr;
      @(negedge clk);
      awaddr = 6'h08; wdata = 32'hA5A55A5A; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      chk("ord_wready_drop", 32'(wready), 32'd0);
      chk("ord_awready_up",  32'(awready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("ord_wready_held", 32'(wready), 32'd0);
      awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      t = 0;
      while (!bvalid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("ord_bvalid_seen", 32'(bvalid), 32'd1);
      rsp0 = bresp;
      chk("ord_bresp", 32'(rsp0), 32'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_bvalid_stable", 32'(bvalid), 32'd1);
         chk("bp_bresp_stable",  32'(bresp),  32'(rsp0));
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("bp_bvalid_clear", 32'(bvalid), 32'd0);
      @(negedge clk);
      chk("bp_wr_done_once", 32'(n_wr - wr0), 32'd1);

      // unmapped offset
      axi_write(6'h10, 32'hDEADBEEF, 4'hF, rsp, lat);
      chk("unmap_bresp", 32'(rsp), 32'd3);
      axi_read(6'h10, rd, rsp, lat);
      chk("unmap_rresp", 32'(rsp), 32'd3);
      chk("unmap_rdata", rd, 32'd0);
      for (int i = 0; i < 4; i++) begin
         axi_read(6'(4*i), rd, rsp, lat);
         chk("final_regs", rd, exp_regs[i]);
      end

      // RESP_DELAY = 4 instance: five edges from handshake to VALID
      sel = 1'b1;
      @(negedge clk);
      axi_write(6'h04, 32'h0BADF00D, 4'hF, rsp, lat);
      chk("d4_wlat",  32'(lat), 32'd5);
      chk("d4_bresp", 32'(rsp), 32'd0);
      axi_read(6'h04, rd, rsp, lat);
      chk("d4_rlat",  32'(lat), 32'd5);
      chk("d4_rdata", rd, 32'h0BADF00D);

      // reset in the middle of the W_DELAY countdown
      @(negedge clk);
      awaddr = 6'h00; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
      chk("mid_rst_awready", 32'(awready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_awready", 32'(awready), 32'd1);
      chk("post_rst_wready",  32'(wready),  32'd1);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("post_rst_no_bvalid", 32'(bvalid), 32'd0);
      end
      bready = 1'b0;
      axi_read(6'h00, rd, rsp, lat);
      chk("post_rst_reg0", rd, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
